// File: rtl/conv1_window_scheduler_if.sv
// Handshake/bus bundle between the window scheduler, its pixel memory,
// the convolution datapath and the result consumer.
interface conv1_window_scheduler_if #(
    parameter int ADDR_W  = 6,
    parameter int OADDR_W = 6
);
    logic               start;
    logic               busy;
    logic               done;
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [3:0]         mem_data;
    logic [3:0]         tap_n;
    logic [3:0]         tap_w;
    logic [3:0]         tap_c;
    logic [3:0]         tap_e;
    logic [3:0]         tap_s;
    logic               conv_issue;
    logic [7:0]         conv_result;
    logic               res_valid;
    logic [7:0]         res_data;
    logic [OADDR_W-1:0] res_addr;

    modport master (
        input  start, mem_data, conv_result,
        output busy, done, mem_rd, mem_addr,
        output tap_n, tap_w, tap_c, tap_e, tap_s,
        output conv_issue, res_valid, res_data, res_addr
    );

    modport slave (
        output start, mem_data, conv_result,
        input  busy, done, mem_rd, mem_addr,
        input  tap_n, tap_w, tap_c, tap_e, tap_s,
        input  conv_issue, res_valid, res_data, res_addr
    );
endinterface

// File: rtl/conv1_window_scheduler.sv
// Walks every interior pixel of the image, fetches its plus-shaped 5-tap
// window, issues it to the datapath and tags each result with its output address.
module conv1_window_scheduler #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int ADDR_W   = 6,
    parameter int OADDR_W  = 6,
    parameter int PIPE_LAT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    conv1_window_scheduler_if.master bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] FIRST_CTR = ADDR_W'(IMG_W + 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(IMG_W - 2);
    localparam logic [RW-1:0]     LAST_ROW  = RW'(IMG_H - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           k_q;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic [ADDR_W-1:0]    ctr_q;
    logic [OADDR_W-1:0]   oaddr_q;
    logic [3:0]           tap_q [5];
    logic [PIPE_LAT-1:0]  vld_q;
    logic [OADDR_W-1:0]   adr_q [PIPE_LAT];
    logic                 res_valid_q;
    logic [7:0]           res_data_q;
    logic [OADDR_W-1:0]   res_addr_q;

    logic issue;
    logic last_win;

    assign issue    = (state_q == S_ISSUE);
    assign last_win = (row_q == LAST_ROW) && (col_q == LAST_COL);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d        = state_q;
        bus.mem_rd     = 1'b0;
        bus.mem_addr   = '0;
        bus.conv_issue = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.busy   = 1'b1;
                bus.mem_rd = (k_q <= 3'd4);
                case (k_q)
                    3'd0:    bus.mem_addr = ctr_q - ROW_STEP;
                    3'd1:    bus.mem_addr = ctr_q - ADDR_W'(1);
                    3'd2:    bus.mem_addr = ctr_q;
                    3'd3:    bus.mem_addr = ctr_q + ADDR_W'(1);
                    3'd4:    bus.mem_addr = ctr_q + ROW_STEP;
                    default: bus.mem_addr = '0;
                endcase
                if (k_q == 3'd5) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                bus.busy       = 1'b1;
                bus.conv_issue = 1'b1;
                state_d        = last_win ? S_DRAIN : S_FETCH;
            end
            S_DRAIN: begin
                bus.busy = 1'b1;
                // Head has shifted out, so the last res_valid is on the bus now.
                if (vld_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Window walker and tap capture
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ctr_q   <= '0;
            oaddr_q <= '0;
            for (int i = 0; i < 5; i++) tap_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        k_q     <= '0;
                        col_q   <= CW'(1);
                        row_q   <= RW'(1);
                        ctr_q   <= FIRST_CTR;
                        oaddr_q <= '0;
                    end
                end
                S_FETCH: begin
                    k_q <= k_q + 3'd1;
                    case (k_q)
                        3'd1:    tap_q[0] <= bus.mem_data;
                        3'd2:    tap_q[1] <= bus.mem_data;
                        3'd3:    tap_q[2] <= bus.mem_data;
                        3'd4:    tap_q[3] <= bus.mem_data;
                        3'd5:    tap_q[4] <= bus.mem_data;
                        default: ;
                    endcase
                end
                S_ISSUE: begin
                    k_q     <= '0;
                    oaddr_q <= oaddr_q + OADDR_W'(1);
                    if (col_q == LAST_COL) begin
                        // Jump from the last interior column to column 1 of the next row.
                        col_q <= CW'(1);
                        row_q <= row_q + RW'(1);
                        ctr_q <= ctr_q + ADDR_W'(3);
                    end else begin
                        col_q <= col_q + CW'(1);
                        ctr_q <= ctr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the latency tracker is small flop storage, not a RAM, so it is
    // reset; a mid-frame reset must kill every in-flight valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) adr_q[i] <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_addr_q  <= '0;
        end else begin
            vld_q[0] <= issue;
            adr_q[0] <= oaddr_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                adr_q[i] <= adr_q[i-1];
            end
            res_valid_q <= vld_q[PIPE_LAT-1];
            if (vld_q[PIPE_LAT-1]) begin
                res_data_q <= bus.conv_result;
                res_addr_q <= adr_q[PIPE_LAT-1];
            end
        end
    end

    assign bus.tap_n     = tap_q[0];
    assign bus.tap_w     = tap_q[1];
    assign bus.tap_c     = tap_q[2];
    assign bus.tap_e     = tap_q[3];
    assign bus.tap_s     = tap_q[4];
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_addr  = res_addr_q;

endmodule

// File: tb/tb_conv1_window_scheduler.sv
// Directed bench: four scheduler builds (4x4/L4, 8x8/L4, 4x4/L1, 4x4/L9), each with
// a behavioural pixel memory and a delayed-sum datapath model.
module tb_conv1_window_scheduler;

    localparam int NI = 4;
    localparam int CFG_W [NI] = '{4, 8, 4, 4};
    localparam int CFG_L [NI] = '{4, 4, 1, 9};

    logic          clk = 1'b0;
    logic [NI-1:0] rst;
    logic [NI-1:0] start_v;
    logic          fill15;

    logic [NI-1:0] o_busy, o_done, o_rd, o_issue, o_rv;
    logic [5:0]    o_addr  [NI];
    logic [7:0]    o_rdata [NI];
    logic [5:0]    o_raddr [NI];
    logic [44:0]   o_all   [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int W = CFG_W[g];
        localparam int L = CFG_L[g];

        conv1_window_scheduler_if #(.ADDR_W(6), .OADDR_W(6)) ifc ();

        conv1_window_scheduler #(
            .IMG_W(W), .IMG_H(W), .ADDR_W(6), .OADDR_W(6), .PIPE_LAT(L)
        ) dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (ifc)
        );

        logic [7:0] pipe [L];

        assign ifc.start       = start_v[g];
        assign ifc.conv_result = pipe[L-1];

        always @(posedge clk) begin
            if (ifc.mem_rd) ifc.mem_data <= fill15 ? 4'hF : ifc.mem_addr[3:0];
        end

        always @(posedge clk) begin
            pipe[0] <= 8'(ifc.tap_n) + 8'(ifc.tap_w) + 8'(ifc.tap_c)
                     + 8'(ifc.tap_e) + 8'(ifc.tap_s);
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end

        assign o_busy[g]  = ifc.busy;
        assign o_done[g]  = ifc.done;
        assign o_rd[g]    = ifc.mem_rd;
        assign o_issue[g] = ifc.conv_issue;
        assign o_rv[g]    = ifc.res_valid;
        assign o_addr[g]  = ifc.mem_addr;
        assign o_rdata[g] = ifc.res_data;
        assign o_raddr[g] = ifc.res_addr;
        assign o_all[g]   = {ifc.busy, ifc.done, ifc.mem_rd, ifc.mem_addr,
                             ifc.tap_n, ifc.tap_w, ifc.tap_c, ifc.tap_e, ifc.tap_s,
                             ifc.conv_issue, ifc.res_valid, ifc.res_data, ifc.res_addr};
    end

    // Per-frame event log, times counted in cycles after the start-accepting edge.
    int rd_t[$], rd_a[$], is_t[$], rs_t[$], rs_a[$], rs_d[$], done_t[$];
    int busy_gap, post_busy, busy_at_done, timed_out;
    longint after_rst;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input int g, input int x0, input int x1, input int x2,
                             input int rst_at, input int post, input int budget);
        int n;
        int stop_at;
        rd_t.delete(); rd_a.delete(); is_t.delete();
        rs_t.delete(); rs_a.delete(); rs_d.delete(); done_t.delete();
        busy_gap = 0; post_busy = 0; busy_at_done = 1; after_rst = -1;
        @(negedge clk);
        start_v[g] = 1'b1;
        @(posedge clk);
        #1 start_v[g] = 1'b0;
        n = 0;
        stop_at = budget;
        while (n < stop_at) begin
            @(negedge clk);
            n++;
            if (o_rd[g]) begin
                rd_t.push_back(n);
                rd_a.push_back(int'(o_addr[g]));
            end
            if (o_issue[g]) is_t.push_back(n);
            if (o_rv[g]) begin
                rs_t.push_back(n);
                rs_a.push_back(int'(o_raddr[g]));
                rs_d.push_back(int'(o_rdata[g]));
            end
            if (done_t.size() != 0 && o_busy[g]) post_busy++;
            if (done_t.size() == 0 && !o_done[g] && !o_busy[g]) busy_gap++;
            if (o_done[g]) begin
                if (done_t.size() == 0) begin
                    busy_at_done = int'(o_busy[g]);
                    stop_at = n + post;
                end
                done_t.push_back(n);
            end
            if (rst_at != 0 && n == rst_at + 1) after_rst = longint'(o_all[g]);
            start_v[g] = (n == x0 || n == x1 || n == x2);
            rst[g]     = (rst_at != 0 && n == rst_at);
        end
        start_v[g] = 1'b0;
        rst[g]     = 1'b0;
        timed_out  = (rst_at == 0 && done_t.size() == 0) ? 1 : 0;
    endtask

    // Full ramp-frame check on a 4x4 build with latency lat.
    task automatic check_ramp(input string tag, input int lat);
        int exp_d [4] = '{25, 30, 45, 50};
        check({tag, "_timeout"}, timed_out, 0);
        check({tag, "_rd_count"}, rd_t.size(), 20);
        check({tag, "_res_count"}, rs_t.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_issue_t"}, is_t[i], 7 + 7 * i);
            check({tag, "_res_t"}, rs_t[i], 7 + 7 * i + lat + 1);
            check({tag, "_res_a"}, rs_a[i], i);
            check({tag, "_res_d"}, rs_d[i], exp_d[i]);
        end
        check({tag, "_done_t"}, done_t[0], 28 + lat + 2);
        check({tag, "_done_count"}, done_t.size(), 1);
        check({tag, "_busy_gap"}, busy_gap, 0);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
    endtask

    function automatic int sweep_sum(input int i, input bit all15);
        int ctr;
        ctr = (1 + i / 6) * 8 + (1 + i % 6);
        if (all15) return 75;
        return ((ctr - 8) % 16) + ((ctr - 1) % 16) + (ctr % 16)
             + ((ctr + 1) % 16) + ((ctr + 8) % 16);
    endfunction

    initial begin
        int exp_rd [5];
        rst     = '1;
        start_v = '0;
        fill15  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) check("reset_state", o_all[g], 0);
        rst = '0;

        // Plain ramp frame: timing of reads, issues, results and done.
        run_frame(0, 0, 0, 0, 0, 3, 100);
        exp_rd = '{1, 4, 5, 6, 9};
        for (int i = 0; i < 5; i++) begin
            check("ramp_rd_t", rd_t[i], i + 1);
            check("ramp_rd_a", rd_a[i], exp_rd[i]);
        end
        check("ramp_rd_w2_t", rd_t[5], 8);
        check_ramp("ramp", 4);

        // Extra starts while busy and in the done cycle are all ignored.
        run_frame(0, 10, 20, 34, 0, 4, 100);
        check("restart_res_count", rs_t.size(), 4);
        check("restart_done_count", done_t.size(), 1);
        check("restart_post_busy", post_busy, 0);

        // A new frame after done rereads from address 1.
        run_frame(0, 0, 0, 0, 0, 3, 100);
        check("reread_first_addr", rd_a[0], 1);
        check_ramp("reread", 4);

        // Reset mid-frame: everything clears and no stale results appear.
        run_frame(0, 0, 0, 0, 20, 0, 45);
        check("midrst_outputs_zero", after_rst, 0);
        check("midrst_res_before", rs_t.size(), 2);
        check("midrst_done_count", done_t.size(), 0);
        run_frame(0, 0, 0, 0, 0, 3, 100);
        check_ramp("after_rst", 4);

        // 8x8 address sweep with ramp pixels modulo 16.
        run_frame(1, 0, 0, 0, 0, 3, 400);
        check("sweep_timeout", timed_out, 0);
        check("sweep_rd_count", rd_a.size(), 180);
        exp_rd = '{1, 8, 9, 10, 17};
        for (int i = 0; i < 5; i++) check("sweep_first_addr", rd_a[i], exp_rd[i]);
        exp_rd = '{46, 53, 54, 55, 62};
        for (int i = 0; i < 5; i++) check("sweep_last_addr", rd_a[175 + i], exp_rd[i]);
        check("sweep_res_count", rs_t.size(), 36);
        for (int i = 0; i < 36; i++) begin
            check("sweep_res_a", rs_a[i], i);
            check("sweep_res_d", rs_d[i], sweep_sum(i, 1'b0));
        end
        check("sweep_done_t", done_t[0], 258);

        // All pixels 15: every result 75, busy unbroken.
        fill15 = 1'b1;
        run_frame(1, 0, 0, 0, 0, 3, 400);
        fill15 = 1'b0;
        check("flat_timeout", timed_out, 0);
        check("flat_res_count", rs_t.size(), 36);
        for (int i = 0; i < 36; i++) check("flat_res_d", rs_d[i], sweep_sum(i, 1'b1));
        check("flat_busy_gap", busy_gap, 0);

        // Minimum and long latency builds.
        run_frame(2, 0, 0, 0, 0, 3, 100);
        check_ramp("lat1", 1);
        run_frame(3, 0, 0, 0, 0, 3, 100);
        check_ramp("lat9", 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv1_window_scheduler.md
Name: conv1_window_scheduler

Overview:
- Sequences the 5-tap plus-shaped convolution pipeline over an IMG_W x IMG_H 4-bit image held in a synchronous read memory.
- For each interior pixel, fetches the five window taps (N, W, C, E, S) and presents them to the pipeline for exactly one issue cycle.
- Tracks each issued window through the fixed pipeline latency and emits each result with its output-map address.
- Sits between the pixel buffer and the convolution datapath; the datapath's input1..input5 connect to tap_n, tap_w, tap_c, tap_e, tap_s.

Parameters:
- IMG_W, 8, image width in pixels, >= 3
- IMG_H, 8, image height in pixels, >= 3
- ADDR_W, 6, pixel memory address width; 2^ADDR_W >= IMG_W*IMG_H
- OADDR_W, 6, result address width; 2^OADDR_W >= (IMG_W-2)*(IMG_H-2)
- PIPE_LAT, 4, cycles from taps valid at pipeline input to matching conv_result, >= 1

Ports:
- clk, input, 1, rising-edge clock
- reset, input, 1, synchronous active-high reset
- start, input, 1, begin a frame; sampled only in IDLE
- busy, output, 1, high from the cycle after start is accepted until done
- done, output, 1, one-cycle pulse at frame end
- mem_rd, output, 1, pixel memory read strobe
- mem_addr, output, ADDR_W, pixel read address
- mem_data, input, 4, pixel data, valid the cycle after mem_rd
- tap_n / tap_w / tap_c / tap_e / tap_s, output, 4 each, window taps to datapath input1..input5
- conv_issue, output, 1, taps valid this cycle (debug/monitor)
- conv_result, input, 8, datapath output
- res_valid, output, 1, res_data/res_addr valid this cycle
- res_data, output, 8, registered conv_result
- res_addr, output, OADDR_W, row-major output-map index

Behaviour:
- Reset: state IDLE; all outputs 0; tap registers 0; window counters and latency shift register cleared. Reset mid-frame abandons the frame, and in-flight results never raise res_valid.
- Window order: centre row r = 1..IMG_H-2 (outer loop), centre column c = 1..IMG_W-2 (inner loop), row-major.
- Output address: res_addr = (r-1)*(IMG_W-2) + (c-1).
- Tap addresses:
  - N = (r-1)*IMG_W + c
  - W = r*IMG_W + c-1
  - C = r*IMG_W + c
  - E = r*IMG_W + c+1
  - S = (r+1)*IMG_W + c
- States: IDLE, FETCH, ISSUE, DRAIN, DONE.
- IDLE: start=1 -> FETCH; window index set to (1,1); fetch index k = 0.
- FETCH (6 cycles, k = 0..5):
  - k = 0..4: mem_rd = 1 and mem_addr = tap address k, in order N, W, C, E, S.
  - k = 1..5: mem_data is captured into tap k-1.
  - k = 5 -> ISSUE.
- ISSUE (1 cycle):
  - conv_issue = 1; taps are stable and the datapath samples them.
  - Push {1, res_addr} into a PIPE_LAT-deep valid/address shift register.
  - Advance the window index.
  - Last window -> DRAIN; otherwise -> FETCH with k = 0.
  - Window period is 7 cycles.
- Taps are held between issues and change only during FETCH. Datapath outputs for non-issue cycles are ignored because the shift register carries valid = 0 for them.
- Result capture: when the shift-register head is valid, conv_result is sampled and appears on the next cycle with res_valid = 1. That is res_valid at issue + PIPE_LAT + 1, res_data = conv_result sampled at issue + PIPE_LAT.
- res_valid is a single-cycle pulse per window. There is no backpressure; the consumer must accept every pulse.
- DRAIN: wait until the shift register is empty and the final res_valid has been emitted -> DONE.
- DONE: done = 1 for one cycle; busy drops the same cycle; -> IDLE.
- start while busy is ignored, with no queuing. start asserted in the same cycle done pulses is ignored; IDLE sees start the following cycle.
- mem_rd is never asserted outside FETCH k = 0..4.

Test Plan:
- Bench datapath model: PIPE_LAT-cycle delay of (tap_n + tap_w + tap_c + tap_e + tap_s).
- Ramp frame: IMG_W = IMG_H = 4, pixel[i] = i, start accepted at edge t.
  - mem_rd at t+1..t+5.
  - conv_issue at t+7, t+14, t+21, t+28.
  - res_valid at t+12, t+19, t+26, t+33, with (res_addr, res_data) = (0,25), (1,30), (2,45), (3,50).
  - done at t+34.
- Address sweep, IMG_W = IMG_H = 8: mem_addr for window (1,1) = 1, 8, 9, 10, 17; last window (6,6) = 46, 53, 54, 55, 62. Exactly 36 res_valid pulses with res_addr 0..35, in order.
- All pixels = 15 on 8x8: every res_data = 75; busy is continuous from start to done.
- start pulsed again at t+10 and t+20 during the ramp frame: ignored. Exactly 4 results, one done; a new start after done rereads from address 1.
- reset asserted one cycle at t+20 of the ramp frame: all outputs 0 the next cycle; no res_valid ever follows for the abandoned windows; a fresh start yields the full correct ramp sequence.
- PIPE_LAT = 1 and PIPE_LAT = 9 rebuilds: res_valid is exactly PIPE_LAT+1 cycles after each conv_issue; values match the ramp test.
